// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase controller: phase codes, lamp bundle and helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    HW_GREEN  = 3'd0,
    HW_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    CR_GREEN  = 3'd3,
    CR_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    WALK      = 3'd6
  } phase_t;

  typedef struct packed {
    logic h_red;
    logic h_yellow;
    logic h_green;
    logic c_red;
    logic c_yellow;
    logic c_green;
    logic walk;
  } lamps_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One lamp per road in every phase; the walk lamp only with both roads red.
  function automatic lamps_t decode_lamps(input phase_t p);
    lamps_t l;
    l = '0;
    unique case (p)
      HW_GREEN:           begin l.h_green  = 1'b1; l.c_red    = 1'b1; end
      HW_YELLOW:          begin l.h_yellow = 1'b1; l.c_red    = 1'b1; end
      CR_GREEN:           begin l.h_red    = 1'b1; l.c_green  = 1'b1; end
      CR_YELLOW:          begin l.h_red    = 1'b1; l.c_yellow = 1'b1; end
      WALK:               begin l.h_red    = 1'b1; l.c_red    = 1'b1; l.walk = 1'b1; end
      ALLRED_A, ALLRED_B: begin l.h_red    = 1'b1; l.c_red    = 1'b1; end
      default:            begin l.h_red    = 1'b1; l.c_red    = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// Sensor, button and lamp signals of the intersection controller.
interface traffic_phase_controller_if;
  logic       Th;
  logic       Tc;
  logic       button;
  logic       LhRed;
  logic       LhYellow;
  logic       LhGreen;
  logic       LcRed;
  logic       LcYellow;
  logic       LcGreen;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    input  Th, Tc, button,
    output LhRed, LhYellow, LhGreen, LcRed, LcYellow, LcGreen, walk, ped_pending, phase
  );

  modport slave (
    output Th, Tc, button,
    input  LhRed, LhYellow, LhGreen, LcRed, LcYellow, LcGreen, walk, ped_pending, phase
  );
endinterface

// File: rtl/phase_timer.sv
// Tick prescaler plus saturating seconds counter, both restarted by clear on phase entry.
module phase_timer #(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned SEC_MAX     = 20,
  parameter int unsigned SEC_W       = $clog2(SEC_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             tick,
  output logic [SEC_W-1:0] sec_cnt
);
  localparam int unsigned      PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_nxt;

  always_comb begin
    pre_nxt = pre_cnt + PRE_W'(1);
    if (clear || tick) pre_nxt = '0;
  end

  // tick is registered against the next prescaler value so it marks the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= (PRE_LAST == '0);
      sec_cnt <= '0;
    end else begin
      pre_cnt <= pre_nxt;
      tick    <= (pre_nxt == PRE_LAST);
      if (clear)
        sec_cnt <= '0;
      else if (tick && (sec_cnt != SEC_LAST))
        sec_cnt <= sec_cnt + SEC_W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Demand-responsive highway/country/pedestrian phase sequencer with timed green, yellow and clearance.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned MIN_GREEN   = 5,
  parameter int unsigned MAX_GREEN   = 20,
  parameter int unsigned YELLOW_T    = 3,
  parameter int unsigned ALLRED_T    = 1,
  parameter int unsigned WALK_T      = 6
) (
  input logic                        clk,
  input logic                        rst,
  traffic_phase_controller_if.master io
);
  localparam int unsigned SEC_MAX = max_u(max_u(max_u(MIN_GREEN, MAX_GREEN),
                                                max_u(YELLOW_T, ALLRED_T)), WALK_T);
  localparam int unsigned SEC_W   = $clog2(SEC_MAX + 1);
  localparam int unsigned ELA_W   = SEC_W + 1;

  localparam logic [ELA_W-1:0] MIN_E    = ELA_W'(MIN_GREEN);
  localparam logic [ELA_W-1:0] MAX_E    = ELA_W'(MAX_GREEN);
  localparam logic [ELA_W-1:0] YELLOW_E = ELA_W'(YELLOW_T);
  localparam logic [ELA_W-1:0] ALLRED_E = ELA_W'(ALLRED_T);
  localparam logic [ELA_W-1:0] WALK_E   = ELA_W'(WALK_T);

  logic [1:0]       th_sync;
  logic [1:0]       tc_sync;
  logic [1:0]       btn_sync;
  logic             btn_prev;
  logic             th_s;
  logic             tc_s;
  logic             btn_rise;
  phase_t           state;
  phase_t           state_nxt;
  lamps_t           lamps_q;
  lamps_t           lamps_nxt;
  logic             ped_q;
  logic             clear;
  logic             walk_entry;
  logic             tick;
  logic [SEC_W-1:0] sec_cnt;
  logic [ELA_W-1:0] elapsed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      th_sync  <= '0;
      tc_sync  <= '0;
      btn_sync <= '0;
      btn_prev <= 1'b0;
    end else begin
      th_sync  <= {th_sync[0], io.Th};
      tc_sync  <= {tc_sync[0], io.Tc};
      btn_sync <= {btn_sync[0], io.button};
      btn_prev <= btn_sync[1];
    end
  end

  assign th_s     = th_sync[1];
  assign tc_s     = tc_sync[1];
  assign btn_rise = btn_sync[1] & ~btn_prev;

  phase_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .SEC_MAX     (SEC_MAX),
    .SEC_W       (SEC_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .tick    (tick),
    .sec_cnt (sec_cnt)
  );

  // Seconds count as of the next edge, so a D-tick phase ends exactly on its D-th tick.
  assign elapsed = {1'b0, sec_cnt} + ELA_W'(tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HW_GREEN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HW_GREEN:  if ((elapsed >= MIN_E) && (tc_s || ped_q) && (!th_s || (elapsed >= MAX_E)))
                   state_nxt = HW_YELLOW;
      HW_YELLOW: if (elapsed >= YELLOW_E) state_nxt = ALLRED_A;
      ALLRED_A:  if (elapsed >= ALLRED_E) state_nxt = ped_q ? WALK : CR_GREEN;
      CR_GREEN:  if ((elapsed >= MIN_E) && (!tc_s || ped_q || (th_s && (elapsed >= MAX_E))))
                   state_nxt = CR_YELLOW;
      CR_YELLOW: if (elapsed >= YELLOW_E) state_nxt = ALLRED_B;
      ALLRED_B:  if (elapsed >= ALLRED_E) state_nxt = ped_q ? WALK : HW_GREEN;
      WALK:      if (elapsed >= WALK_E)   state_nxt = ALLRED_B;
      default:   state_nxt = HW_GREEN;
    endcase
    clear      = (state_nxt != state);
    walk_entry = (state_nxt == WALK) && (state != WALK);
    lamps_nxt  = decode_lamps(state_nxt);
  end

  // Request latch: clearing on walk entry outranks a coincident press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            ped_q <= 1'b0;
    else if (walk_entry)                ped_q <= 1'b0;
    else if (btn_rise && state != WALK) ped_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lamps_q <= decode_lamps(HW_GREEN);
    else     lamps_q <= lamps_nxt;
  end

  assign io.LhRed       = lamps_q.h_red;
  assign io.LhYellow    = lamps_q.h_yellow;
  assign io.LhGreen     = lamps_q.h_green;
  assign io.LcRed       = lamps_q.c_red;
  assign io.LcYellow    = lamps_q.c_yellow;
  assign io.LcGreen     = lamps_q.c_green;
  assign io.walk        = lamps_q.walk;
  assign io.ped_pending = ped_q;
  assign io.phase       = 3'(state);

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scenario bench for traffic_phase_controller: phase-duration scoreboard plus random lamp-safety run.
module tb_traffic_phase_controller;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  traffic_phase_controller_if io();

  traffic_phase_controller #(
    .TICK_CYCLES (4),
    .MIN_GREEN   (5),
    .MAX_GREEN   (20),
    .YELLOW_T    (3),
    .ALLRED_T    (1),
    .WALK_T      (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    logic [2:0] ph;
    int         cycles;
  } seg_t;

  seg_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected {LhRed,LhYellow,LhGreen,LcRed,LcYellow,LcGreen,walk} for each phase code.
  function automatic logic [6:0] exp_lamps(input logic [2:0] ph);
    case (ph)
      3'd0:    return 7'b001_100_0;
      3'd1:    return 7'b010_100_0;
      3'd2:    return 7'b100_100_0;
      3'd3:    return 7'b100_001_0;
      3'd4:    return 7'b100_010_0;
      3'd5:    return 7'b100_100_0;
      3'd6:    return 7'b100_100_1;
      default: return 7'b000_000_0;
    endcase
  endfunction

  function automatic logic [6:0] obs_lamps();
    return {io.LhRed, io.LhYellow, io.LhGreen, io.LcRed, io.LcYellow, io.LcGreen, io.walk};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0)
      assert (!(io.LhGreen && io.LcGreen))
        else $error("FAIL both_greens LhGreen=%b LcGreen=%b", io.LhGreen, io.LcGreen);
  end

  task automatic apply_reset(input logic th, input logic tc);
    rst       = 1'b1;
    io.Th     = th;
    io.Tc     = tc;
    io.button = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pops one expected {phase, length} per observed phase change; lamps checked every cycle.
  task automatic drain_scoreboard(input string name, input int budget);
    logic [2:0] cur;
    int         run;
    int         n;
    seg_t       e;
    cur = io.phase;
    run = 1;
    n   = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      checks++;
      if (obs_lamps() !== exp_lamps(io.phase)) begin
        errors++;
        $display("FAIL %s_lamps phase=%0d got=%b want=%b", name, io.phase, obs_lamps(), exp_lamps(io.phase));
      end
      if (io.phase === cur) begin
        run++;
      end else begin
        e = sb.pop_front();
        checks++;
        if (cur !== e.ph || run != e.cycles) begin
          errors++;
          $display("FAIL %s_segment got phase=%0d len=%0d want phase=%0d len=%0d",
                   name, cur, run, e.ph, e.cycles);
        end
        cur = io.phase;
        run = 1;
      end
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got %0d segments pending want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    io.Th     = 1'b1;
    io.Tc     = 1'b1;
    io.button = 1'b1;
    #1;
    checks++;
    if (obs_lamps() !== 7'b001_100_0 || io.phase !== 3'd0 || io.ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got lamps=%b phase=%0d ped=%b want lamps=0011000 phase=0 ped=0",
               obs_lamps(), io.phase, io.ped_pending);
    end
  endtask

  task automatic test_hold_highway();
    apply_reset(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (io.phase !== 3'd0 || obs_lamps() !== 7'b001_100_0) begin
        errors++;
        $display("FAIL hold_highway cycle=%0d got phase=%0d lamps=%b want phase=0 lamps=0011000",
                 i, io.phase, obs_lamps());
      end
    end
  endtask

  task automatic test_country_demand();
    apply_reset(1'b0, 1'b1);
    sb.push_back('{ph: 3'd0, cycles: 20});
    sb.push_back('{ph: 3'd1, cycles: 12});
    sb.push_back('{ph: 3'd2, cycles: 4});
    sb.push_back('{ph: 3'd3, cycles: 20});
    sb.push_back('{ph: 3'd4, cycles: 12});
    sb.push_back('{ph: 3'd5, cycles: 4});
    fork
      drain_scoreboard("country", 400);
      begin
        int n;
        n = 0;
        while (io.phase !== 3'd1 && n < 200) begin @(negedge clk); n++; end
        io.Tc = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    checks++;
    if (io.phase !== 3'd0) begin
      errors++;
      $display("FAIL country_return got phase=%0d want 0", io.phase);
    end
  endtask

  task automatic test_max_green();
    apply_reset(1'b1, 1'b1);
    sb.push_back('{ph: 3'd0, cycles: 80});
    drain_scoreboard("max_green", 300);
    checks++;
    if (io.phase !== 3'd1) begin
      errors++;
      $display("FAIL max_green_next got phase=%0d want 1", io.phase);
    end
  endtask

  task automatic test_pedestrian();
    apply_reset(1'b0, 1'b0);
    sb.push_back('{ph: 3'd0, cycles: 20});
    sb.push_back('{ph: 3'd1, cycles: 12});
    sb.push_back('{ph: 3'd2, cycles: 4});
    sb.push_back('{ph: 3'd6, cycles: 24});
    sb.push_back('{ph: 3'd5, cycles: 4});
    fork
      drain_scoreboard("ped", 400);
      begin
        int n;
        repeat (4) @(negedge clk);
        io.button = 1'b1;
        repeat (3) @(negedge clk);
        io.button = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (io.ped_pending !== 1'b1) begin
          errors++;
          $display("FAIL ped_latched got %b want 1", io.ped_pending);
        end
        n = 0;
        while (io.phase !== 3'd6 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (io.phase !== 3'd6 || io.ped_pending !== 1'b0 || io.walk !== 1'b1) begin
          errors++;
          $display("FAIL ped_walk_entry got phase=%0d ped=%b walk=%b want phase=6 ped=0 walk=1",
                   io.phase, io.ped_pending, io.walk);
        end
        repeat (5) @(negedge clk);
        io.button = 1'b1;
        repeat (3) @(negedge clk);
        io.button = 1'b0;
        n = 0;
        while (io.phase !== 3'd5 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (io.ped_pending !== 1'b0) begin
          errors++;
          $display("FAIL ped_walk_press_ignored got %b want 0", io.ped_pending);
        end
      end
    join
    checks++;
    if (io.phase !== 3'd0 || io.ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL ped_return got phase=%0d ped=%b want phase=0 ped=0", io.phase, io.ped_pending);
    end
  endtask

  task automatic test_reset_mid_phase();
    int n;
    apply_reset(1'b0, 1'b1);
    n = 0;
    while (io.phase !== 3'd3 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (io.phase !== 3'd3) begin
      errors++;
      $display("FAIL midrst_reach_cr_green got phase=%0d want 3", io.phase);
    end
    io.button = 1'b1;
    repeat (3) @(negedge clk);
    io.button = 1'b0;
    n = 0;
    while (io.phase !== 3'd4 && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++;
    if (io.phase !== 3'd4 || io.ped_pending !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got phase=%0d ped=%b want phase=4 ped=1", io.phase, io.ped_pending);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_lamps() !== 7'b001_100_0 || io.phase !== 3'd0 || io.ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort got lamps=%b phase=%0d ped=%b want lamps=0011000 phase=0 ped=0",
               obs_lamps(), io.phase, io.ped_pending);
    end
    io.Tc = 1'b0;
  endtask

  task automatic test_random();
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      checks++;
      if ((io.LhGreen && io.LcGreen) ||
          ($countones({io.LhRed, io.LhYellow, io.LhGreen}) != 1) ||
          ($countones({io.LcRed, io.LcYellow, io.LcGreen}) != 1) ||
          (io.walk && !(io.LhRed && io.LcRed))) begin
        errors++;
        $display("FAIL random_safety cycle=%0d got lamps=%b want one lamp per road, no double green",
                 i, obs_lamps());
      end
      checks++;
      if (obs_lamps() !== exp_lamps(io.phase)) begin
        errors++;
        $display("FAIL random_decode cycle=%0d phase=%0d got=%b want=%b",
                 i, io.phase, obs_lamps(), exp_lamps(io.phase));
      end
      if ($urandom_range(49) == 0) io.Th = ~io.Th;
      if ($urandom_range(49) == 0) io.Tc = ~io.Tc;
      if ($urandom_range(29) == 0) io.button = ~io.button;
    end
  endtask

  initial begin
    rst       = 1'b1;
    io.Th     = 1'b0;
    io.Tc     = 1'b0;
    io.button = 1'b0;
    test_reset();
    test_hold_highway();
    test_country_demand();
    test_max_green();
    test_pedestrian();
    test_reset_mid_phase();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Demand-responsive sequencer for the two-road intersection (highway "h", country road "c") with a pedestrian phase.
- Takes the Th/Tc car sensors and the pedestrian button.
- Drives the six lamp outputs plus a walk lamp, with timed minimum/maximum green, yellow and all-red clearance intervals.
- Sits in place of the fixed traffic_light FSM under the board top and uses the same sensor/lamp naming.

Parameters:
- TICK_CYCLES, 100_000_000, clk cycles per 1 s timing tick (bench uses 4).
- MIN_GREEN, 5, minimum green duration in ticks, either road.
- MAX_GREEN, 20, maximum green in ticks while the opposing road has demand.
- YELLOW_T, 3, yellow duration in ticks.
- ALLRED_T, 1, all-red clearance in ticks.
- WALK_T, 6, pedestrian walk duration in ticks.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- Th, input, 1, highway car present (asynchronous, level).
- Tc, input, 1, country-road car present (asynchronous, level).
- button, input, 1, pedestrian request (asynchronous, raw).
- LhRed / LhYellow / LhGreen, output, 1 each, highway lamps.
- LcRed / LcYellow / LcGreen, output, 1 each, country lamps.
- walk, output, 1, pedestrian walk lamp.
- ped_pending, output, 1, latched pedestrian request.
- phase, output, 3, current state encoding for debug.

Behaviour:
- Reset is asynchronous, active-high.
  - State = HW_GREEN, timer = 0.
  - ped_pending = 0, synchronizers cleared.
  - Outputs: LhGreen = 1, LcRed = 1, all other lamps 0, walk = 0, phase = 0.
  - Reset mid-phase aborts immediately to these values.
- Th, Tc and button each pass through a 2-FF synchronizer; all decisions use the synchronized values.
- Button: a rising edge of the synchronized button sets ped_pending.
  - ped_pending clears on the cycle WALK is entered.
  - An edge while in WALK is ignored.
  - An edge in the same cycle as WALK entry is ignored (clear wins).
- Timer:
  - Prescaler counts 0..TICK_CYCLES-1 and pulses tick at terminal count.
  - sec_cnt increments on tick.
  - Prescaler and sec_cnt both reset to 0 on every state entry.
  - A timed state of D ticks therefore lasts exactly D*TICK_CYCLES cycles.
- States and phase code:
  - HW_GREEN = 0. Lamps LhGreen, LcRed.
    - Leave to HW_YELLOW when sec_cnt ≥ MIN_GREEN and demand = (Tc or ped_pending) and (not Th or sec_cnt ≥ MAX_GREEN).
    - With no demand, stays indefinitely; sec_cnt saturates at MAX_GREEN.
  - HW_YELLOW = 1. Lamps LhYellow, LcRed; lasts YELLOW_T.
  - ALLRED_A = 2. Lamps LhRed, LcRed; lasts ALLRED_T. Then WALK if ped_pending, else CR_GREEN.
  - CR_GREEN = 3. Lamps LhRed, LcGreen.
    - Leave to CR_YELLOW when sec_cnt ≥ MIN_GREEN and (not Tc or ped_pending or (Th and sec_cnt ≥ MAX_GREEN)).
  - CR_YELLOW = 4. Lamps LhRed, LcYellow; lasts YELLOW_T.
  - ALLRED_B = 5. Lamps both red; lasts ALLRED_T. Then WALK if ped_pending, else HW_GREEN.
  - WALK = 6. Lamps both red, walk = 1; lasts WALK_T. Then ALLRED_B; the exit decision at ALLRED_B sees ped_pending = 0, so it goes to HW_GREEN.
- Timed-state exit: next state is loaded on the cycle after the tick that makes sec_cnt reach the duration.
- Outputs are registered and decoded from the state register.
  - Invariant: exactly one lamp per road is on in every cycle.
  - Green on both roads is never allowed; the bench asserts this.
- sec_cnt width is clog2(max duration + 1); the counter never wraps.
- Simultaneous Th and Tc in HW_GREEN: highway holds until MAX_GREEN.
- Tc dropping during HW_YELLOW or ALLRED_A does not abort the sequence; ALLRED_A still goes to CR_GREEN, which exits at MIN_GREEN.

Decomposition:
- Package traffic_pkg holds the phase_t enum (the 7 codes above) and the lamp-bundle struct.
- Sub-module phase_timer contains the prescaler, sec_cnt, tick output and clear input; parameter TICK_CYCLES.
- The 2-FF synchronizers are inline.

Test Plan:
All scenarios use TICK_CYCLES = 4 and default durations.
1. Reset, Th = 1, Tc = 0, no button for 200 cycles → phase stays 0, LhGreen = 1, LcRed = 1 throughout.
2. Th = 0, raise Tc at cycle 0 → HW_YELLOW entered at 20 cycles (plus sync latency), yellow lasts 12 cycles, all-red 4 cycles, then CR_GREEN. When Tc drops, CR_GREEN exits after MIN_GREEN.
3. Th = 1, Tc = 1 held → HW_GREEN lasts exactly 80 cycles before HW_YELLOW.
4. Pulse button once during HW_GREEN with Tc = 0 → ped_pending = 1, then sequence HW_YELLOW → ALLRED_A → WALK (walk = 1 for 24 cycles, ped_pending = 0) → ALLRED_B → HW_GREEN. A second press during WALK is not latched.
5. Assert rst mid CR_YELLOW → same cycle LhGreen = 1, LcRed = 1, phase = 0, ped_pending = 0.
6. Random Th, Tc and button for 10k cycles → never both greens, exactly one lamp per road, walk only with both reds.
